// File: rtl/mem_ctrler.sv
`default_nettype none
// ============================================================================
// mem_ctrler : serialises fetcher line fills and LSU loads/stores onto a
//              byte-wide RAM port (read data returns one cycle after address).
// Revision   : 1.0
// ============================================================================
module mem_ctrler #(
    parameter int LINE_BYTES = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    io_buffer_full,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr,
    input  logic                    valid_from_inst_fetcher,
    input  logic [ADDR_WIDTH-1:0]   addr_from_inst_fetcher,
    output logic                    ready_to_inst_fetcher,
    output logic [LINE_BYTES*8-1:0] cache_line_to_inst_fetcher,
    input  logic                    valid_from_lsu,
    input  logic                    wr_from_lsu,
    input  logic [ADDR_WIDTH-1:0]   addr_from_lsu,
    input  logic [1:0]              size_from_lsu,
    input  logic [31:0]             data_from_lsu,
    output logic                    ready_to_lsu,
    output logic [31:0]             data_to_lsu,
    input  logic                    reset_from_rob_bus
);

    localparam int IW = $clog2(LINE_BYTES);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_IF_READ  = 3'd1;
    localparam logic [2:0] c_LS_READ  = 3'd2;
    localparam logic [2:0] c_LS_WRITE = 3'd3;
    localparam logic [2:0] c_DONE     = 3'd4;

    localparam logic [IW-1:0]         c_IDX_ONE   = IW'(1);
    localparam logic [IW-1:0]         c_IDX_WORD  = IW'(3);
    localparam logic [IW-1:0]         c_LINE_LAST = IW'(LINE_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_LINE_MASK = ~(ADDR_WIDTH'(LINE_BYTES - 1));

    logic [2:0]              r_state;
    logic [2:0]              w_next_state;
    logic                    r_src_lsu;
    logic [ADDR_WIDTH-1:0]   r_mem_a;
    logic [7:0]              r_mem_dout;
    logic [31:0]             r_wdata;
    logic [IW-1:0]           r_iss;
    logic [IW-1:0]           r_cap;
    logic [IW-1:0]           r_last;
    logic                    r_pend;
    logic [LINE_BYTES*8-1:0] r_buf;
    logic [LINE_BYTES*8-1:0] r_line;
    logic [31:0]             r_lsu_data;

    logic [IW-1:0]           w_lsu_last;
    logic [LINE_BYTES*8-1:0] w_buf_fill;
    logic                    w_accept_lsu;
    logic                    w_accept_if;
    logic                    w_io_stall;
    logic                    w_rd_last;
    logic                    w_wr_last;

    assign w_accept_lsu = valid_from_lsu && !reset_from_rob_bus;
    assign w_accept_if  = valid_from_inst_fetcher && !w_accept_lsu;
    assign w_io_stall   = (r_mem_a[17:16] == 2'b11) && io_buffer_full;
    // r_pend marks that mem_din now carries the byte for an address already issued
    assign w_rd_last    = r_pend && (r_cap == r_last);
    assign w_wr_last    = (r_iss == r_last) && !w_io_stall;

    always_comb begin
        case (size_from_lsu)
            2'd0:    w_lsu_last = '0;
            2'd1:    w_lsu_last = c_IDX_ONE;
            default: w_lsu_last = c_IDX_WORD;
        endcase
    end

    always_comb begin
        w_buf_fill = r_buf;
        w_buf_fill[{r_cap, 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else if (rdy) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept_lsu) begin
                    w_next_state = wr_from_lsu ? c_LS_WRITE : c_LS_READ;
                end else if (w_accept_if) begin
                    w_next_state = c_IF_READ;
                end
            end
            c_IF_READ: begin
                if (w_rd_last) w_next_state = c_DONE;
            end
            c_LS_READ: begin
                if (reset_from_rob_bus) begin
                    w_next_state = c_IDLE;
                end else if (w_rd_last) begin
                    w_next_state = c_DONE;
                end
            end
            c_LS_WRITE: begin
                if (w_wr_last) w_next_state = c_DONE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Write strobe is gated by rdy so a frozen write cycle is not repeated
    always_comb begin
        mem_wr                = (r_state == c_LS_WRITE) && rdy && !w_io_stall;
        ready_to_lsu          = (r_state == c_DONE) && r_src_lsu;
        ready_to_inst_fetcher = (r_state == c_DONE) && !r_src_lsu;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_src_lsu  <= 1'b0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_wdata    <= '0;
            r_iss      <= '0;
            r_cap      <= '0;
            r_last     <= '0;
            r_pend     <= 1'b0;
            r_buf      <= '0;
            r_line     <= '0;
            r_lsu_data <= '0;
        end else if (rdy) begin
            case (r_state)
                c_IDLE: begin
                    r_iss  <= '0;
                    r_cap  <= '0;
                    r_pend <= 1'b0;
                    r_buf  <= '0;
                    if (w_accept_lsu) begin
                        r_src_lsu  <= 1'b1;
                        r_mem_a    <= addr_from_lsu;
                        r_wdata    <= data_from_lsu;
                        r_mem_dout <= data_from_lsu[7:0];
                        r_last     <= w_lsu_last;
                    end else if (w_accept_if) begin
                        r_src_lsu  <= 1'b0;
                        r_mem_a    <= addr_from_inst_fetcher & c_LINE_MASK;
                        r_last     <= c_LINE_LAST;
                    end
                end
                c_IF_READ, c_LS_READ: begin
                    if ((r_state == c_LS_READ) && reset_from_rob_bus) begin
                        r_mem_a <= '0;
                    end else begin
                        r_pend <= 1'b1;
                        if (r_iss != r_last) begin
                            r_iss   <= r_iss + c_IDX_ONE;
                            r_mem_a <= r_mem_a + c_ADDR_ONE;
                        end
                        if (r_pend) begin
                            r_buf <= w_buf_fill;
                            r_cap <= r_cap + c_IDX_ONE;
                            if (r_cap == r_last) begin
                                r_mem_a <= '0;
                                if (r_src_lsu) begin
                                    r_lsu_data <= w_buf_fill[31:0];
                                end else begin
                                    r_line <= w_buf_fill;
                                end
                            end
                        end
                    end
                end
                c_LS_WRITE: begin
                    if (!w_io_stall) begin
                        if (r_iss == r_last) begin
                            r_mem_a <= '0;
                        end else begin
                            r_iss      <= r_iss + c_IDX_ONE;
                            r_mem_a    <= r_mem_a + c_ADDR_ONE;
                            r_mem_dout <= r_wdata[15:8];
                            r_wdata    <= r_wdata >> 8;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_a                      = r_mem_a;
    assign mem_dout                   = r_mem_dout;
    assign cache_line_to_inst_fetcher = r_line;
    assign data_to_lsu                = r_lsu_data;

endmodule
`default_nettype wire
